// File: rtl/alu_sched_pkg.sv
// Shared definitions for the two-port ALU scheduler: opcodes, flag bit
// positions, FSM state encoding and the multi-cycle opcode classifier.
package alu_sched_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_MOD = 3'd7;

  // Bit positions inside the 4-bit {V,C,Z,S} flag vector.
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 0;

  // Hold counter width; wide enough for the largest legal latency (15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } sched_state_e;

  // Opcodes that occupy the ALU for the configured multi-cycle latency.
  function automatic logic is_multicycle(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_scheduler_alu.sv
// Shared combinational ALU. Add/sub report carry (sub: borrow, a < b unsigned)
// and signed overflow; all other ops clear V and C. Division by zero yields
// all ones, modulo by zero yields the dividend.
module alu_scheduler_alu
  import alu_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           carry;
  logic           ovf;

  // Opcode decode and flag generation.
  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i};
    diff     = {1'b0, a_i} - {1'b0, b_i};
    result_o = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        ovf      = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        result_o = diff[WIDTH-1:0];
        carry    = diff[WIDTH];
        ovf      = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_MUL:  result_o = a_i * b_i;
      OP_DIV:  result_o = (b_i == '0) ? '1 : a_i / b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_MOD:  result_o = (b_i == '0) ? a_i : a_i % b_i;
      default: result_o = '0;
    endcase
    flags_o         = '0;
    flags_o[FLAG_V] = ovf;
    flags_o[FLAG_C] = carry;
    flags_o[FLAG_Z] = (result_o == '0);
    flags_o[FLAG_S] = result_o[WIDTH-1];
  end

endmodule

// File: rtl/alu_scheduler.sv
// Two-requester round-robin scheduler in front of the shared ALU.
// Handshakes: a request transfers on a rising edge where reqN_valid and
// reqN_ready are both high; a response transfers on a rising edge where
// resp_valid and resp_ready are both high. Requesters hold valid/payload
// stable until ready; response registers stay stable while stalled.
// Optional feature macro: ALU_DIVZERO_TRAP_EN (div/mod by zero reports
// resp_err with a zero result and skips the multi-cycle hold).
// dbg_state exposes the FSM state for observation.
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4,   // legal 1..15
  parameter int unsigned WIDTH      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic [3:0]       resp_flags,
  output logic             resp_err,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MULDIV_LAT - 1);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             id_q;
  logic             resp_id_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  logic             any_valid;
  logic             win_id;
  logic [WIDTH-1:0] win_a, win_b;
  logic [2:0]       win_op;
  logic [CNT_W-1:0] cnt_start;
  logic             grant;
  logic             capture;
  logic             trap_win;
  logic             trap_exec;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

`ifdef ALU_DIVZERO_TRAP_EN
  assign trap_win  = ((win_op == OP_DIV) || (win_op == OP_MOD)) && (win_b == '0);
  assign trap_exec = ((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_q == '0);
`else
  assign trap_win  = 1'b0;
  assign trap_exec = 1'b0;
`endif

  // Round-robin winner: a lone valid wins; on a tie the port that was not
  // granted last wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      win_id = ~last_q;
    end else begin
      win_id = req1_valid;
    end
    win_a     = win_id ? req1_a  : req0_a;
    win_b     = win_id ? req1_b  : req0_b;
    win_op    = win_id ? req1_op : req0_op;
    cnt_start = (is_multicycle(win_op) && !trap_win) ? LAT_CNT : '0;
  end

  // Next-state logic; grants happen from IDLE or on the HOLD handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant   = 1'b1;
          cnt_d   = cnt_start;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (resp_ready) begin
          if (any_valid) begin
            grant   = 1'b1;
            cnt_d   = cnt_start;
            state_d = ST_EXEC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response payload: trapped div/mod-by-zero overrides the ALU output.
  always_comb begin
    if (trap_exec) begin
      result_d        = '0;
      flags_d         = '0;
      flags_d[FLAG_Z] = 1'b1;
      err_d           = 1'b1;
    end else begin
      result_d = alu_result;
      flags_d  = alu_flags;
      err_d    = 1'b0;
    end
  end

  // State, operand latch and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      id_q      <= 1'b0;
      resp_id_q <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        a_q    <= win_a;
        b_q    <= win_b;
        op_q   <= win_op;
        id_q   <= win_id;
        last_q <= win_id;
      end
      if (capture) begin
        resp_id_q <= id_q;
        result_q  <= result_d;
        flags_q   <= flags_d;
        err_q     <= err_d;
      end
    end
  end

  alu_scheduler_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a_i     (a_q),
    .b_i     (b_q),
    .op_i    (op_q),
    .result_o(alu_result),
    .flags_o (alu_flags)
  );

  assign req0_ready  = grant & ~win_id;
  assign req1_ready  = grant & win_id;
  assign resp_valid  = (state_q == ST_HOLD);
  assign resp_id     = resp_id_q;
  assign resp_result = result_q;
  assign resp_flags  = flags_q;
  assign resp_err    = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: an arithmetic reference model fills an
// expected-response queue, a negedge monitor checks every response cycle,
// grant legality and accept-to-response latency.
module tb_alu_scheduler;

  localparam int LAT = 4;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        err;
    logic [4:0]  lat;
  } exp_t;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  logic [31:0] resp_result;
  logic [3:0]  resp_flags;
  logic [1:0]  dbg_state;

  alu_scheduler #(.MULDIV_LAT(LAT), .WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_result(resp_result),
    .resp_flags (resp_flags),
    .resp_err   (resp_err),
    .dbg_state  (dbg_state)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc = 0;
  logic busy = 1'b0;
  logic prev_valid = 1'b0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the opcode's meaning.
  function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op);
    exp_t e;
    longint unsigned ua, ub, full;
    longint sa, sb, sfull;
    logic [31:0] r;
    logic v, c;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    v = 1'b0; c = 1'b0; r = '0; full = 0; sfull = 0;
    case (op)
      3'd0: begin full = ua + ub; r = full[31:0]; c = (full > 64'hFFFF_FFFF); sfull = sa + sb; end
      3'd1: begin full = ua - ub; r = full[31:0]; c = (ua < ub); sfull = sa - sb; end
      3'd2: begin full = ua * ub; r = full[31:0]; end
      3'd3: r = (ub == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = (ub == 0) ? a : 32'(ua % ub);
    endcase
    if (op == 3'd0 || op == 3'd1) v = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
    e.id    = id;
    e.res   = r;
    e.flags = {v, c, (r == 32'd0), r[31]};
    e.err   = 1'b0;
    e.lat   = (op == 3'd2 || op == 3'd3 || op == 3'd7) ? 5'(LAT + 1) : 5'd2;
`ifdef ALU_DIVZERO_TRAP_EN
    if ((op == 3'd3 || op == 3'd7) && b == 32'd0) begin
      e.res = '0; e.flags = 4'b0010; e.err = 1'b1; e.lat = 5'd2;
    end
`endif
    return e;
  endfunction

  // Scoreboard / protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      busy       = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (req0_ready || req1_ready) begin
        chk("one_grant", {31'd0, req0_ready & req1_ready}, 32'd0);
        chk("grant_needs_valid", {31'd0, (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)}, 32'd0);
        chk("grant_allowed", {31'd0, ~busy | (resp_valid & resp_ready)}, 32'd1);
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", {31'd0, resp_valid}, 32'd0);
        end else begin
          if (!prev_valid) chk("latency", 32'(cyc - last_acc), 32'(exp_q[0].lat));
          chk("resp_id", {31'd0, resp_id}, {31'd0, exp_q[0].id});
          chk("resp_result", resp_result, exp_q[0].res);
          chk("resp_flags", {28'd0, resp_flags}, {28'd0, exp_q[0].flags});
          chk("resp_err", {31'd0, resp_err}, {31'd0, exp_q[0].err});
          if (resp_ready) begin
            void'(exp_q.pop_front());
            busy = 1'b0;
          end
        end
      end
      if (req0_ready || req1_ready) begin
        busy     = 1'b1;
        last_acc = cyc;
      end
      prev_valid = resp_valid;
    end
  end

  // Driver: present one request and hold it until accepted.
  task automatic issue(input bit port, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    int n = 0;
    logic got = 1'b0;
    if (port) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    else      begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      got = port ? req1_ready : req0_ready;
    end
    chk(port ? "accept1" : "accept0", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    exp_t m;
    rst = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
    chk("rst_resp_result", resp_result, 32'd0);
    chk("rst_resp_flags", {28'd0, resp_flags}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);

    // Hand-computed pins on the model
    m = model(1'b0, 32'd5, 32'd7, 3'd0);
    chk("pin_add_res", m.res, 32'd12);
    chk("pin_add_flags", {28'd0, m.flags}, 32'd0);
    m = model(1'b1, 32'd100, 32'd7, 3'd3);
    chk("pin_div_res", m.res, 32'd14);
    chk("pin_div_lat", {27'd0, m.lat}, 32'd5);
    m = model(1'b0, 32'd1, 32'd2, 3'd1);
    chk("pin_sub_res", m.res, 32'hFFFF_FFFF);
    chk("pin_sub_flags", {28'd0, m.flags}, 32'b0101);
    m = model(1'b0, 32'h7FFF_FFFF, 32'd1, 3'd0);
    chk("pin_ovf_flags", {28'd0, m.flags}, 32'b1001);
    @(posedge clk); #1;

    // Single add on port 0
    exp_q.push_back(model(1'b0, 32'd5, 32'd7, 3'd0));
    issue(1'b0, 32'd5, 32'd7, 3'd0);
    drain();

    // Contention from reset: grants 0,1,0,1
    do_reset();
    exp_q.push_back(model(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd4));
    exp_q.push_back(model(1'b1, 32'h1234_5678, 32'hFFFF_0000, 3'd4));
    exp_q.push_back(model(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 3'd4));
    exp_q.push_back(model(1'b1, 32'h8000_0001, 32'h8000_0000, 3'd4));
    fork
      begin
        issue(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd4);
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 3'd4);
      end
      begin
        issue(1'b1, 32'h1234_5678, 32'hFFFF_0000, 3'd4);
        issue(1'b1, 32'h8000_0001, 32'h8000_0000, 3'd4);
      end
    join
    drain();

    // Multicycle divide; port 0 raised mid-execution must wait
    exp_q.push_back(model(1'b1, 32'd100, 32'd7, 3'd3));
    exp_q.push_back(model(1'b0, 32'd3, 32'd4, 3'd0));
    fork
      issue(1'b1, 32'd100, 32'd7, 3'd3);
      begin repeat (2) @(posedge clk); #1; issue(1'b0, 32'd3, 32'd4, 3'd0); end
    join
    drain();

    // Backpressure: six stalled response cycles, pending port 1 waits
    resp_ready = 1'b0;
    exp_q.push_back(model(1'b0, 32'd1, 32'd2, 3'd1));
    exp_q.push_back(model(1'b1, 32'd6, 32'd3, 3'd2));
    fork
      issue(1'b0, 32'd1, 32'd2, 3'd1);
      begin @(posedge clk); #1; issue(1'b1, 32'd6, 32'd3, 3'd2); end
      begin repeat (8) @(posedge clk); #1 resp_ready = 1'b1; end
    join
    drain();

    // Flag and opcode corners
    exp_q.push_back(model(1'b0, 32'h7FFF_FFFF, 32'd1, 3'd0));
    issue(1'b0, 32'h7FFF_FFFF, 32'd1, 3'd0);
    exp_q.push_back(model(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd0));
    issue(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd0);
    exp_q.push_back(model(1'b0, 32'd9, 32'd4, 3'd7));
    issue(1'b0, 32'd9, 32'd4, 3'd7);
    exp_q.push_back(model(1'b1, 32'hA5A5_A5A5, 32'hFFFF_0000, 3'd5));
    issue(1'b1, 32'hA5A5_A5A5, 32'hFFFF_0000, 3'd5);
    exp_q.push_back(model(1'b0, 32'h0000_1234, 32'h0000_1234, 3'd6));
    issue(1'b0, 32'h0000_1234, 32'h0000_1234, 3'd6);
    exp_q.push_back(model(1'b1, 32'h8000_0000, 32'd1, 3'd1));
    issue(1'b1, 32'h8000_0000, 32'd1, 3'd1);
    exp_q.push_back(model(1'b0, 32'h0000_FFFF, 32'h0001_0001, 3'd2));
    issue(1'b0, 32'h0000_FFFF, 32'h0001_0001, 3'd2);
`ifdef ALU_DIVZERO_TRAP_EN
    exp_q.push_back(model(1'b1, 32'd9, 32'd0, 3'd7));
    issue(1'b1, 32'd9, 32'd0, 3'd7);
`endif
    drain();

    // Reset mid-execution of a multiply: no response, pointer restored
    do_reset();
    issue(1'b0, 32'd3, 32'd5, 3'd2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("drop_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    exp_q.push_back(model(1'b0, 32'd10, 32'd20, 3'd0));
    exp_q.push_back(model(1'b1, 32'd10, 32'd20, 3'd1));
    fork
      issue(1'b0, 32'd10, 32'd20, 3'd0);
      issue(1'b1, 32'd10, 32'd20, 3'd1);
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Two-requester scheduler that shares the single 32-bit ALU between the integer pipeline (port 0) and the address/branch unit (port 1). Arbitrates round-robin, latches the winner's operands and opcode, holds the ALU for a configurable latency on multiply/divide/modulo, and returns the result plus V/C/Z/S flags tagged with the requester ID over a valid/ready response channel. Sits between the issue stage and writeback; it is the only instantiator of the ALU.

## Interface
- MULDIV_LAT, 4: cycles the ALU is held for ops 2 (mul), 3 (div), 7 (mod); legal 1..15
- WIDTH, 32: operand/result width; fixed to 32 to match the ALU
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid / req1_valid  in  1  request pending
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- req0_op / req1_op  in  3  ALU opcode (0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 mod)
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  requester that issued the operation
- resp_result  out  32  ALU result
- resp_flags  out  4  {V,C,Z,S} from the ALU
- resp_err  out  1  divide/modulo by zero (only with ALU_DIVZERO_TRAP_EN; tied 0 otherwise)

## Operation
- FSM states: IDLE, EXEC, HOLD. Reset -> IDLE.
- Grant: round-robin, pointer `last` = last granted ID; reset value 1, so port 0 wins first tie.
- IDLE: if any valid, grant one (only valid wins; both valid -> port != last). Asserted req_ready for the winner only; operands/op/ID latched; last updated. Go to EXEC with counter = (op in {2,3,7}) ? MULDIV_LAT-1 : 0.
- EXEC: ALU driven from latched operands. Counter == 0 -> capture result, flags, err into response registers, go HOLD. Else decrement.
- HOLD: resp_valid=1. On resp_ready: response consumed; if any req valid in the same cycle, grant per round-robin (req_ready asserted, combinational from resp_ready) and go EXEC; else go IDLE.
- Request inputs are ignored while not granted; requesters must hold valid and payload stable until ready.
- Response registers stable while resp_valid && !resp_ready.

## Timing
- Reset values: req*_ready 0, resp_valid 0, resp_id 0, resp_result 0, resp_flags 0, resp_err 0, last 1, counter 0.
- Latency accept -> resp_valid: 2 cycles for single-cycle ops, MULDIV_LAT+1 for mul/div/mod.
- Back-to-back: a new request may be accepted in the cycle the previous response handshakes; max throughput one op per 2 cycles.
- Reset asserted mid-EXEC or mid-HOLD: operation dropped, no response emitted, state/pointer return to reset values next edge.
- resp_ready while in IDLE/EXEC: ignored.

## Configuration
- ALU_DIVZERO_TRAP_EN defined: op 3 or 7 with b == 0 sets resp_err=1, forces resp_result=0 and resp_flags=4'b0010 (Z only) and skips the multi-cycle hold (counter = 0); ALU result is not used.
- Undefined: no check; resp_err tied 0; ALU output passed through unchanged for all operands.

## Structure
- Package alu_sched_pkg: opcode localparams (OP_ADD..OP_MOD), is_multicycle function, FSM state typedef, flag bit index constants (FLAG_V=3, FLAG_C=2, FLAG_Z=1, FLAG_S=0).
- One sub-module: the existing ALU, instantiated once, fed from the latched operand registers.

## Test plan
- Single add: req0 a=5, b=7, op=0, resp_ready=1 -> resp_valid 2 cycles after accept, result=12, flags=0000, id=0.
- Contention: both valid from reset, op=4 each -> grant order 0,1,0,1; each response carries the matching id.
- Multicycle: MULDIV_LAT=4, req1 a=100, b=7, op=3 -> resp_valid 5 cycles after accept, result=14; req0 raised during EXEC gets no ready until HOLD handshake.
- Backpressure: resp_ready=0 for 6 cycles after sub a=1, b=2 -> result 0xFFFFFFFF, flags S=1, C=1, held stable; no new req_ready until resp_ready=1.
- Divide by zero (macro on): a=9, b=0, op=7 -> resp_err=1, result=0, flags=0010, latency 2 cycles.
- Reset mid-EXEC of a mul -> no resp_valid; next request from port 0 served first.
